ctrl_pipe: RTL and testbench
============================

CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 SHALL have parameter ALIGN_STAGES, default 1, number of register stages between instruction capture and decode; legal range 1..4.
REQ-002 SHALL have parameter WBE_WIDTH, default 4, data-memory write byte-enable width; legal values 4 (RV32) and 8 (RV64).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  in_* fields carry an instruction this cycle.
REQ-006 in_opcode  input  7  instruction opcode.
REQ-007 in_funct3  input  3  instruction funct3.
REQ-008 in_rd, in_rs1, in_rs2  input  5 each  register specifiers.
REQ-009 stall  input  1  downstream hold; freezes the whole pipe.
REQ-010 take_branch  input  1  branch outcome for the instruction in the final stage.
REQ-011 out_valid  output  1  final stage holds a real instruction, not a bubble.
REQ-012 pc_mux, wren_rf, csrw_mux, se2_ctrl  output  1 each  decoded controls.
REQ-013 wd_mux, alu_mux, branch_mux, dm_mux, rbyteen_dm  output  2 each  decoded controls.
REQ-014 wbyteen_dm  output  WBE_WIDTH  store byte enables.
REQ-015 flush  output  1  one-cycle pulse on a pipeline redirect.
REQ-016 load_use_stall  output  1  upstream must hold its in_* fields this cycle.

Function
REQ-017 SHALL hold an ALIGN_STAGES-deep shift register of {valid, opcode, funct3, rd, rs1, rs2}; stage 0 captures in_*, and the last stage is the "final stage".
REQ-018 SHALL derive all decoded outputs combinationally from the final stage, ANDed with its valid bit; every decoded output SHALL be 0 when out_valid=0.
REQ-019 Decode (op = final opcode, f3 = final funct3):
- pc_mux = op in {1101111, 1100111}, or (op = 1100011 and take_branch).
- wren_rf = op not in {1100011, 0100011}.
- csrw_mux = (op = 1110011 and f3[2]).
- se2_ctrl = (op = 1100011).
- rbyteen_dm = f3[1:0].
REQ-020 Decode, continued:
- wd_mux = 01 for op 0110111, 10 for op 0010111, else 00.
- alu_mux[0] = (op = 0010011 and f3[1:0] = 01) or op[5:0] = 100011.
- alu_mux[1] = op in {1100111, 0000011, 0010011} or op[5:0] = 100011.
REQ-021 Decode, continued:
- dm_mux[0] = op = 0000011 and (f3 = 010 or f3[2:1] = 10).
- dm_mux[1] = op = 0000011 and f3[1] = 0.
- branch_mux[0] = op in {0010111, 0110111, 1101111}.
- branch_mux[1] = op in {1100111, 0000011, 1101111}.
REQ-022 wbyteen_dm SHALL be nonzero only for op = 0100011: f3 0 -> 0x1, 1 -> 0x3, 2 -> 0xF, 3 -> 0xFF (WBE_WIDTH = 8 only); for any other f3, or f3 = 3 with WBE_WIDTH = 4, it SHALL be 0, upper bits zero-filled.
REQ-023 Priority per cycle SHALL be stall > redirect > load-use > normal advance.
REQ-024 stall = 1: all stages SHALL hold; flush = 0 and load_use_stall = 0; decoded outputs SHALL keep reflecting the held final stage.
REQ-025 Redirect, defined as pc_mux = 1 and stall = 0: flush = 1 that cycle; on the next edge every stage's valid SHALL clear, the incoming in_* included (bubble everywhere).
REQ-026 Load-use: final op = 0000011, final rd != 0, and the next-to-enter entry has valid = 1 with rs1 or rs2 = final rd. The next-to-enter entry is stage ALIGN_STAGES-2, or in_* when ALIGN_STAGES = 1.
REQ-027 On load-use without stall or redirect: load_use_stall = 1; the final stage SHALL load a bubble; all earlier stages and the upstream in_* SHALL hold.
REQ-028 Normal advance: each stage SHALL take the previous stage's contents; stage 0 takes in_* with valid = in_valid.
REQ-029 Latency SHALL be exactly ALIGN_STAGES cycles from in_valid capture to out_valid, absent stall, redirect or load-use.
REQ-030 flush and load_use_stall SHALL be combinational and never asserted together.

Reset
REQ-031 rst_n low SHALL immediately clear all stage valid bits; all outputs then read 0, including flush and load_use_stall.
REQ-032 Reset asserted mid-operation SHALL discard in-flight instructions; after release, the first capture occurs on the first rising edge with rst_n high.

Verification
REQ-033 ALIGN_STAGES = 2: in_valid = 1 with LUI (0110111) at t0 -> at t0+2, out_valid = 1, wd_mux = 01, wren_rf = 1, branch_mux = 01.
REQ-034 WBE_WIDTH = 8: SD (0100011, f3 = 3) -> wbyteen_dm = 0xFF; same stimulus with WBE_WIDTH = 4 -> 0x0.
REQ-035 BEQ in final stage with take_branch = 1 and two younger valid entries -> pc_mux = 1 and flush = 1 for one cycle; next cycle out_valid = 0 and all stages empty.
REQ-036 ALIGN_STAGES = 1: LW rd = 5 in final stage, in_rs2 = 5 -> load_use_stall = 1; next cycle out_valid = 0 and the held instruction then advances.
REQ-037 Redirect or load-use condition present while stall = 1 for 3 cycles -> outputs frozen, flush = 0, load_use_stall = 0; the event acts on the first cycle with stall = 0.
REQ-038 rst_n pulsed low with a full pipe -> out_valid and all outputs 0 asynchronously; no stale instruction appears after release.

Source files
------------

// File: rtl/ctrl_pipe_if.sv
// Control-pipe handshake bundle.
// Instruction fields in, decoded controls out.
interface ctrl_pipe_if #(
  parameter int WBE_WIDTH = 4
);
  logic                 in_valid;
  logic [6:0]           in_opcode;
  logic [2:0]           in_funct3;
  logic [4:0]           in_rd;
  logic [4:0]           in_rs1;
  logic [4:0]           in_rs2;
  logic                 stall;
  logic                 take_branch;
  logic                 out_valid;
  logic                 pc_mux;
  logic                 wren_rf;
  logic                 csrw_mux;
  logic                 se2_ctrl;
  logic [1:0]           wd_mux;
  logic [1:0]           alu_mux;
  logic [1:0]           branch_mux;
  logic [1:0]           dm_mux;
  logic [1:0]           rbyteen_dm;
  logic [WBE_WIDTH-1:0] wbyteen_dm;
  logic                 flush;
  logic                 load_use_stall;

  modport master (
    output in_valid, in_opcode, in_funct3,
    output in_rd, in_rs1, in_rs2,
    output stall, take_branch,
    input  out_valid, pc_mux, wren_rf,
    input  csrw_mux, se2_ctrl, wd_mux,
    input  alu_mux, branch_mux, dm_mux,
    input  rbyteen_dm, wbyteen_dm,
    input  flush, load_use_stall
  );

  modport slave (
    input  in_valid, in_opcode, in_funct3,
    input  in_rd, in_rs1, in_rs2,
    input  stall, take_branch,
    output out_valid, pc_mux, wren_rf,
    output csrw_mux, se2_ctrl, wd_mux,
    output alu_mux, branch_mux, dm_mux,
    output rbyteen_dm, wbyteen_dm,
    output flush, load_use_stall
  );
endinterface

// File: rtl/ctrl_pipe.sv
// Instruction align pipe with final-stage decode,
// branch redirect flush and load-use interlock.
module ctrl_pipe #(
  parameter int ALIGN_STAGES = 1,
  parameter int WBE_WIDTH    = 4
) (
  input logic       clk,
  input logic       rst_n,
  ctrl_pipe_if.slave bus
);
  typedef struct packed {
    logic       v;
    logic [6:0] op;
    logic [2:0] f3;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } stg_t;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_OPI   = 7'b0010011;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  stg_t st [ALIGN_STAGES];
  stg_t inp;
  stg_t fin;
  stg_t nx;

  assign inp = '{v:   bus.in_valid,
                 op:  bus.in_opcode,
                 f3:  bus.in_funct3,
                 rd:  bus.in_rd,
                 rs1: bus.in_rs1,
                 rs2: bus.in_rs2};
  assign fin = st[ALIGN_STAGES-1];

  generate
    if (ALIGN_STAGES == 1) begin : g_nx_in
      assign nx = inp;
    end else begin : g_nx_st
      assign nx = st[ALIGN_STAGES-2];
    end
  endgenerate

  logic       v;
  logic [6:0] op;
  logic [2:0] f3;
  assign v  = fin.v;
  assign op = fin.op;
  assign f3 = fin.f3;

  logic is_lui, is_auipc, is_jal, is_jalr;
  logic is_br, is_ld, is_st, is_opi, is_sys;
  logic is_mem_op;
  assign is_lui    = v && op == OP_LUI;
  assign is_auipc  = v && op == OP_AUIPC;
  assign is_jal    = v && op == OP_JAL;
  assign is_jalr   = v && op == OP_JALR;
  assign is_br     = v && op == OP_BR;
  assign is_ld     = v && op == OP_LD;
  assign is_st     = v && op == OP_ST;
  assign is_opi    = v && op == OP_OPI;
  assign is_sys    = v && op == OP_SYS;
  assign is_mem_op = v && op[5:0] == 6'b100011;

  logic pc_mux;
  logic redir;
  logic lu_hit;
  logic lu;
  assign pc_mux = is_jal | is_jalr
                | (is_br & bus.take_branch);
  assign redir  = pc_mux & ~bus.stall;
  assign lu_hit = is_ld && fin.rd != 5'd0
               && nx.v
               && (nx.rs1 == fin.rd
                   || nx.rs2 == fin.rd);
  assign lu     = lu_hit & ~bus.stall & ~redir;

  assign bus.out_valid      = v;
  assign bus.pc_mux         = pc_mux;
  assign bus.wren_rf        = v & ~is_br & ~is_st;
  assign bus.csrw_mux       = is_sys & f3[2];
  assign bus.se2_ctrl       = is_br;
  assign bus.rbyteen_dm     = {2{v}} & f3[1:0];
  assign bus.flush          = redir;
  assign bus.load_use_stall = lu;

  assign bus.alu_mux[0] =
    (is_opi && f3[1:0] == 2'b01) | is_mem_op;
  assign bus.alu_mux[1] =
    is_jalr | is_ld | is_opi | is_mem_op;
  assign bus.dm_mux[0] =
    is_ld && (f3 == 3'b010 || f3[2:1] == 2'b10);
  assign bus.dm_mux[1]     = is_ld & ~f3[1];
  assign bus.branch_mux[0] = is_auipc | is_lui | is_jal;
  assign bus.branch_mux[1] = is_jalr | is_ld | is_jal;

  // writeback source: upper-immediate kinds only
  always_comb begin
    bus.wd_mux = 2'b00;
    unique case (1'b1)
      is_lui:   bus.wd_mux = 2'b01;
      is_auipc: bus.wd_mux = 2'b10;
      default:  bus.wd_mux = 2'b00;
    endcase
  end

  logic [7:0] wbe;

  // store byte enables by access size
  always_comb begin
    wbe = 8'h00;
    if (is_st) begin
      case (f3)
        3'd0:    wbe = 8'h01;
        3'd1:    wbe = 8'h03;
        3'd2:    wbe = 8'h0F;
        3'd3:    wbe = (WBE_WIDTH == 8) ? 8'hFF : 8'h00;
        default: wbe = 8'h00;
      endcase
    end
  end

  assign bus.wbyteen_dm = wbe[WBE_WIDTH-1:0];

  // stall holds, redirect empties, load-use bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ALIGN_STAGES; i++)
        st[i] <= '0;
    end else if (bus.stall) begin
      for (int i = 0; i < ALIGN_STAGES; i++)
        st[i] <= st[i];
    end else if (redir) begin
      for (int i = 0; i < ALIGN_STAGES; i++)
        st[i] <= '0;
    end else if (lu) begin
      st[ALIGN_STAGES-1] <= '0;
    end else begin
      st[0] <= inp;
      for (int i = 1; i < ALIGN_STAGES; i++)
        st[i] <= st[i-1];
    end
  end

  logic unused_bits;
  assign unused_bits = ^{fin.rs1, fin.rs2,
                         nx.op, nx.f3, nx.rd};
endmodule

// File: tb/tb_ctrl_pipe.sv
// Randomized scoreboard bench for ctrl_pipe
// at depths 2/1/4 and byte-enable widths 8/4/8.
module tb_ctrl_pipe;
  typedef struct packed {
    logic       v;
    logic [6:0] op;
    logic [2:0] f3;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ent_t;

  typedef struct packed {
    logic       ov;
    logic       pc;
    logic       wren;
    logic       csrw;
    logic       se2;
    logic [1:0] wd;
    logic [1:0] alu;
    logic [1:0] bm;
    logic [1:0] dm;
    logic [1:0] rb;
    logic [7:0] wbe;
    logic       fl;
    logic       lus;
  } exp_t;

  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] BR    = 7'b1100011;
  localparam logic [6:0] LD    = 7'b0000011;
  localparam logic [6:0] ST    = 7'b0100011;
  localparam logic [6:0] OPI   = 7'b0010011;
  localparam logic [6:0] SYS   = 7'b1110011;
  localparam int NC = 3000;

  logic clk;
  logic rst_n;

  ctrl_pipe_if #(.WBE_WIDTH(8)) ia ();
  ctrl_pipe_if #(.WBE_WIDTH(4)) ib ();
  ctrl_pipe_if #(.WBE_WIDTH(8)) ic ();

  ctrl_pipe #(.ALIGN_STAGES(2), .WBE_WIDTH(8)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(ia.slave));
  ctrl_pipe #(.ALIGN_STAGES(1), .WBE_WIDTH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(ib.slave));
  ctrl_pipe #(.ALIGN_STAGES(4), .WBE_WIDTH(8)) u_c (
    .clk(clk), .rst_n(rst_n), .bus(ic.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t pk(
    logic ov, logic pc, logic wr, logic cs, logic se,
    logic [1:0] wd, logic [1:0] al, logic [1:0] bm,
    logic [1:0] dm, logic [1:0] rb, logic [7:0] wb,
    logic fl, logic lu);
    return {ov, pc, wr, cs, se, wd, al, bm,
            dm, rb, wb, fl, lu};
  endfunction

  exp_t act [3];
  assign act[0] = pk(ia.out_valid, ia.pc_mux,
    ia.wren_rf, ia.csrw_mux, ia.se2_ctrl, ia.wd_mux,
    ia.alu_mux, ia.branch_mux, ia.dm_mux,
    ia.rbyteen_dm, ia.wbyteen_dm, ia.flush,
    ia.load_use_stall);
  assign act[1] = pk(ib.out_valid, ib.pc_mux,
    ib.wren_rf, ib.csrw_mux, ib.se2_ctrl, ib.wd_mux,
    ib.alu_mux, ib.branch_mux, ib.dm_mux,
    ib.rbyteen_dm, {4'h0, ib.wbyteen_dm}, ib.flush,
    ib.load_use_stall);
  assign act[2] = pk(ic.out_valid, ic.pc_mux,
    ic.wren_rf, ic.csrw_mux, ic.se2_ctrl, ic.wd_mux,
    ic.alu_mux, ic.branch_mux, ic.dm_mux,
    ic.rbyteen_dm, ic.wbyteen_dm, ic.flush,
    ic.load_use_stall);

  int   nvec  = 0;
  int   nfail = 0;
  bit   run   = 0;
  exp_t q [3][$];

  ent_t m [3][4];
  int   dep [3] = '{2, 1, 4};
  bit   w8 [3]  = '{1'b1, 1'b0, 1'b1};
  ent_t cin;
  bit   cst;
  bit   ctb;

  logic [6:0] ops [15] = '{LUI, AUIPC, JAL, JALR, BR,
    LD, LD, LD, ST, ST, OPI, OPI, SYS,
    7'b0110011, 7'b0001111};

  // per-instruction decode table
  function automatic exp_t dec(ent_t e, bit tb, bit w);
    exp_t r = '0;
    if (!e.v) return r;
    r.ov = 1'b1;
    r.wren = 1'b1;
    r.rb = e.f3[1:0];
    case (e.op)
      LUI:   begin r.wd = 2'b01; r.bm = 2'b01; end
      AUIPC: begin r.wd = 2'b10; r.bm = 2'b01; end
      JAL:   begin r.pc = 1'b1; r.bm = 2'b11; end
      JALR:  begin
        r.pc = 1'b1; r.alu = 2'b10; r.bm = 2'b10;
      end
      BR: begin
        r.pc = tb; r.wren = 1'b0;
        r.se2 = 1'b1; r.alu = 2'b11;
      end
      LD: begin
        r.alu = 2'b10; r.bm = 2'b10;
        r.dm[1] = e.f3 inside {0, 1, 4, 5};
        r.dm[0] = e.f3 inside {2, 4, 5};
      end
      ST: begin
        r.wren = 1'b0; r.alu = 2'b11;
        case (e.f3)
          0: r.wbe = 8'h01;
          1: r.wbe = 8'h03;
          2: r.wbe = 8'h0F;
          3: r.wbe = w ? 8'hFF : 8'h00;
          default: r.wbe = 8'h00;
        endcase
      end
      OPI: r.alu = {1'b1, e.f3[1:0] == 2'b01};
      SYS: r.csrw = e.f3[2];
      default: ;
    endcase
    return r;
  endfunction

  function automatic exp_t eval_k(int k);
    exp_t e;
    ent_t f;
    ent_t n;
    f = m[k][dep[k]-1];
    if (dep[k] == 1) n = cin;
    else n = m[k][dep[k]-2];
    e = dec(f, ctb, w8[k]);
    e.fl = e.pc && !cst;
    e.lus = !cst && !e.fl && f.v && f.op == LD
         && f.rd != 0 && n.v
         && (n.rs1 == f.rd || n.rs2 == f.rd);
    return e;
  endfunction

  task automatic step_k(int k);
    exp_t e;
    e = eval_k(k);
    if (cst) return;
    if (e.fl) begin
      for (int i = 0; i < 4; i++) m[k][i] = '0;
    end else if (e.lus) begin
      m[k][dep[k]-1] = '0;
    end else begin
      for (int i = dep[k]-1; i > 0; i--)
        m[k][i] = m[k][i-1];
      m[k][0] = cin;
    end
  endtask

  task automatic clr_models();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 4; i++) m[k][i] = '0;
  endtask

  task automatic drive();
    ia.in_valid = cin.v;   ib.in_valid = cin.v;
    ic.in_valid = cin.v;
    ia.in_opcode = cin.op; ib.in_opcode = cin.op;
    ic.in_opcode = cin.op;
    ia.in_funct3 = cin.f3; ib.in_funct3 = cin.f3;
    ic.in_funct3 = cin.f3;
    ia.in_rd = cin.rd;     ib.in_rd = cin.rd;
    ic.in_rd = cin.rd;
    ia.in_rs1 = cin.rs1;   ib.in_rs1 = cin.rs1;
    ic.in_rs1 = cin.rs1;
    ia.in_rs2 = cin.rs2;   ib.in_rs2 = cin.rs2;
    ic.in_rs2 = cin.rs2;
    ia.stall = cst; ib.stall = cst; ic.stall = cst;
    ia.take_branch = ctb; ib.take_branch = ctb;
    ic.take_branch = ctb;
  endtask

  task automatic chk_zero(string nm);
    for (int k = 0; k < 3; k++) begin
      nvec++;
      if (act[k] !== '0) begin
        nfail++;
        $display("FAIL %s dut%0d got %h want 0",
                 nm, k, act[k]);
      end
    end
  endtask

  // monitor: one expected bundle per DUT per cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (run) begin
        for (int k = 0; k < 3; k++) begin
          nvec++;
          if (q[k].size() == 0) begin
            nfail++;
            $display("FAIL sb_empty dut%0d", k);
          end else begin
            e = q[k].pop_front();
            if (act[k] !== e) begin
              nfail++;
              $display("FAIL out dut%0d t=%0t got %h want %h",
                       k, $time, act[k], e);
            end
          end
        end
      end
    end
  end

  initial begin
    bit   hold;
    exp_t e;
    rst_n = 1'b0;
    cin = '0; cst = 1'b0; ctb = 1'b0;
    hold = 1'b0;
    drive();
    clr_models();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset_init");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < NC; c++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) step_k(k);
      if (c % 800 == 799) begin
        #1 rst_n = 1'b0;
        #1;
        clr_models();
        chk_zero("reset_async");
        for (int k = 0; k < 3; k++)
          q[k].push_back('0);
        run = 1'b1;
        @(negedge clk);
        #1 rst_n = 1'b1;
        hold = 1'b0;
      end else begin
        if (!hold) begin
          cin.v   = $urandom_range(0, 9) != 0;
          cin.op  = ops[$urandom_range(0, 14)];
          cin.f3  = 3'($urandom_range(0, 7));
          cin.rd  = 5'($urandom_range(0, 3));
          cin.rs1 = 5'($urandom_range(0, 3));
          cin.rs2 = 5'($urandom_range(0, 3));
        end
        cst = $urandom_range(0, 5) == 0;
        ctb = 1'($urandom_range(0, 1));
        drive();
        hold = 1'b0;
        for (int k = 0; k < 3; k++) begin
          e = eval_k(k);
          if (e.lus) hold = 1'b1;
          q[k].push_back(e);
        end
        run = 1'b1;
      end
    end
    @(negedge clk);
    #1;
    run = 1'b0;
    for (int k = 0; k < 3; k++) begin
      nvec++;
      if (q[k].size() != 0) begin
        nfail++;
        $display("FAIL sb_left dut%0d got %0d want 0",
                 k, q[k].size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nfail);
    $finish;
  end
endmodule
